// File: rtl/clock_pkg.sv
// Shared time-of-day definitions: field limits, widths, the packed time record
// and the 24 h -> 12 h display conversion.
package clock_pkg;

  localparam int SEC_W    = 6;
  localparam int MIN_W    = 6;
  localparam int HOUR_W   = 5;
  localparam int HOUR12_W = 4;

  localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;
  localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
  localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;

  typedef struct packed {
    logic [HOUR_W-1:0] hour;
    logic [MIN_W-1:0]  min;
    logic [SEC_W-1:0]  sec;
  } time_t;

  typedef struct packed {
    logic                pm;
    logic [HOUR12_W-1:0] hour12;
  } hour12_t;

  function automatic hour12_t to_12h(input logic [HOUR_W-1:0] hour);
    hour12_t r;
    r.pm = (hour >= 5'd12);
    if (hour == '0)
      r.hour12 = 4'd12;
    else if (hour > 5'd12)
      r.hour12 = HOUR12_W'(hour - 5'd12);
    else
      r.hour12 = HOUR12_W'(hour);
    return r;
  endfunction

endpackage

// File: rtl/rtc_timekeeper_if.sv
// Control, load and time/alarm status bundle between a host and rtc_timekeeper.
interface rtc_timekeeper_if;
  import clock_pkg::*;

  logic                EN;
  logic                LOAD;
  logic [SEC_W-1:0]    LD_SEC;
  logic [MIN_W-1:0]    LD_MIN;
  logic [HOUR_W-1:0]   LD_HOUR;
  logic                ALM_LOAD;
  logic [MIN_W-1:0]    ALM_MIN;
  logic [HOUR_W-1:0]   ALM_HOUR;
  logic                ALM_EN;

  logic [SEC_W-1:0]    SEC;
  logic [MIN_W-1:0]    MIN;
  logic [HOUR_W-1:0]   HOUR;
  logic [HOUR12_W-1:0] HOUR12;
  logic                PM;
  logic                SEC_TICK;
  logic                DAY_WRAP;
  logic                ALARM;
  logic                LOAD_ERR;

  modport master (
    output EN, LOAD, LD_SEC, LD_MIN, LD_HOUR, ALM_LOAD, ALM_MIN, ALM_HOUR, ALM_EN,
    input  SEC, MIN, HOUR, HOUR12, PM, SEC_TICK, DAY_WRAP, ALARM, LOAD_ERR
  );

  modport slave (
    input  EN, LOAD, LD_SEC, LD_MIN, LD_HOUR, ALM_LOAD, ALM_MIN, ALM_HOUR, ALM_EN,
    output SEC, MIN, HOUR, HOUR12, PM, SEC_TICK, DAY_WRAP, ALARM, LOAD_ERR
  );

endinterface

// File: rtl/tick_prescaler.sv
// Divides the system clock down to a one-cycle advance strobe every TICK_DIV
// enabled cycles; CLR restarts the second so a fresh load gets a full period.
module tick_prescaler #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic CLK,
  input  logic RST,
  input  logic EN,
  input  logic CLR,
  output logic TICK
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge CLK) begin
    if (RST)
      r_cnt <= '0;
    else if (CLR)
      r_cnt <= '0;
    else if (EN)
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
  end

  // Held EN freezes the count, so a paused second resumes where it stopped.
  assign TICK = EN && (r_cnt == LAST);

endmodule

// File: rtl/rtc_timekeeper.sv
// Time-of-day counter: validated time/alarm loads, second/minute/hour carry,
// minute-resolution alarm and registered 12 h display outputs.
module rtc_timekeeper
  import clock_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000
) (
  input logic             CLK,
  input logic             RST,
  rtc_timekeeper_if.slave rtc
);

  logic w_tick;
  logic w_ld_valid, w_ld_ok, w_ld_bad;
  logic w_alm_valid, w_alm_ok, w_alm_bad;
  logic w_next_tick, w_next_wrap, w_next_alarm;

  time_t   w_ld_time, w_adv_time, w_next;
  hour12_t w_next12;

  time_t               r_time;
  logic [MIN_W-1:0]    r_alm_min;
  logic [HOUR_W-1:0]   r_alm_hour;
  logic [HOUR12_W-1:0] r_hour12;
  logic                r_pm, r_sec_tick, r_day_wrap, r_alarm, r_load_err;

  assign w_ld_time   = '{hour: rtc.LD_HOUR, min: rtc.LD_MIN, sec: rtc.LD_SEC};
  assign w_ld_valid  = (rtc.LD_SEC <= SEC_MAX) && (rtc.LD_MIN <= MIN_MAX) && (rtc.LD_HOUR <= HOUR_MAX);
  assign w_ld_ok     = rtc.LOAD && w_ld_valid;
  assign w_ld_bad    = rtc.LOAD && !w_ld_valid;
  assign w_alm_valid = (rtc.ALM_MIN <= MIN_MAX) && (rtc.ALM_HOUR <= HOUR_MAX);
  assign w_alm_ok    = rtc.ALM_LOAD && w_alm_valid;
  assign w_alm_bad   = rtc.ALM_LOAD && !w_alm_valid;

  // Only an accepted load restarts the second; a rejected one leaves the phase alone.
  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .CLK  (CLK),
    .RST  (RST),
    .EN   (rtc.EN),
    .CLR  (w_ld_ok),
    .TICK (w_tick)
  );

  // NOTE: every signal written in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    w_adv_time = r_time;
    if (r_time.sec == SEC_MAX) begin
      w_adv_time.sec = '0;
      if (r_time.min == MIN_MAX) begin
        w_adv_time.min  = '0;
        w_adv_time.hour = (r_time.hour == HOUR_MAX) ? '0 : r_time.hour + 1'b1;
      end else begin
        w_adv_time.min = r_time.min + 1'b1;
      end
    end else begin
      w_adv_time.sec = r_time.sec + 1'b1;
    end
  end

  // A load wins over a coincident advance and never raises the alarm.
  always_comb begin
    w_next       = r_time;
    w_next_tick  = 1'b0;
    w_next_wrap  = 1'b0;
    w_next_alarm = 1'b0;
    if (w_ld_ok) begin
      w_next = w_ld_time;
    end else if (w_tick) begin
      w_next       = w_adv_time;
      w_next_tick  = 1'b1;
      w_next_wrap  = (r_time.hour == HOUR_MAX) && (r_time.min == MIN_MAX) && (r_time.sec == SEC_MAX);
      w_next_alarm = rtc.ALM_EN && (w_adv_time.hour == r_alm_hour)
                     && (w_adv_time.min == r_alm_min) && (w_adv_time.sec == '0);
    end
  end

  assign w_next12 = to_12h(w_next.hour);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_time     <= '0;
      r_alm_min  <= '0;
      r_alm_hour <= '0;
      r_hour12   <= 4'd12;
      r_pm       <= 1'b0;
      r_sec_tick <= 1'b0;
      r_day_wrap <= 1'b0;
      r_alarm    <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_time     <= w_next;
      r_hour12   <= w_next12.hour12;
      r_pm       <= w_next12.pm;
      r_sec_tick <= w_next_tick;
      r_day_wrap <= w_next_wrap;
      r_alarm    <= w_next_alarm;
      r_load_err <= w_ld_bad || w_alm_bad;
      if (w_alm_ok) begin
        r_alm_min  <= rtc.ALM_MIN;
        r_alm_hour <= rtc.ALM_HOUR;
      end
    end
  end

  assign rtc.SEC      = r_time.sec;
  assign rtc.MIN      = r_time.min;
  assign rtc.HOUR     = r_time.hour;
  assign rtc.HOUR12   = r_hour12;
  assign rtc.PM       = r_pm;
  assign rtc.SEC_TICK = r_sec_tick;
  assign rtc.DAY_WRAP = r_day_wrap;
  assign rtc.ALARM    = r_alarm;
  assign rtc.LOAD_ERR = r_load_err;

endmodule

// File: tb/tb_rtc_timekeeper.sv
// Scoreboard bench: the driver predicts each cycle's outputs from a
// seconds-of-day model and queues them; the monitor compares one entry per cycle.
module tb_rtc_timekeeper;
  import clock_pkg::*;

  localparam int DIV = 4;
  localparam int DAY = 86400;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  rtc_timekeeper_if bus0 ();
  rtc_timekeeper_if bus1 ();

  rtc_timekeeper #(.TICK_DIV(DIV)) u_dut (.CLK(CLK), .RST(RST), .rtc(bus0));
  rtc_timekeeper #(.TICK_DIV(1))   u_dut1 (.CLK(CLK), .RST(RST), .rtc(bus1));

  typedef struct {
    int tag;
    int sec, min, hour, hour12;
    bit pm, tick, wrap, alarm, err;
    int sec1, min1;
    bit tick1;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int   n_checks = 0;
  int   n_err    = 0;

  bit d_rst, d_en, d_load, d_aload, d_alm_en;
  int d_ls, d_lm, d_lh, d_am, d_ah;

  int m_t, m_phase, m_alm_h, m_alm_m, m_t1;

  function automatic string tag_name(input int tag);
    case (tag)
      0: return "reset";
      1: return "count_from_reset";
      2: return "day_wrap";
      3: return "bad_load";
      4: return "alarm";
      5: return "load_on_terminal";
      6: return "bad_load_on_terminal";
      7: return "en_hold_then_reset";
      default: return "random";
    endcase
  endfunction

  task automatic cycle(input int tag);
    exp_t e;
    bit ld_ok, a_ok, adv;
    @(negedge CLK);
    RST           = d_rst;
    bus0.EN       = d_en;
    bus0.LOAD     = d_load;
    bus0.LD_SEC   = 6'(d_ls);
    bus0.LD_MIN   = 6'(d_lm);
    bus0.LD_HOUR  = 5'(d_lh);
    bus0.ALM_LOAD = d_aload;
    bus0.ALM_MIN  = 6'(d_am);
    bus0.ALM_HOUR = 5'(d_ah);
    bus0.ALM_EN   = d_alm_en;
    bus1.EN       = d_en;

    e = '{default: 0};
    e.tag = tag;
    if (d_rst) begin
      m_t = 0; m_phase = 0; m_alm_h = 0; m_alm_m = 0; m_t1 = 0;
    end else begin
      ld_ok = d_load && d_ls <= 59 && d_lm <= 59 && d_lh <= 23;
      a_ok  = d_aload && d_am <= 59 && d_ah <= 23;
      adv   = d_en && (m_phase == DIV - 1);
      e.err = (d_load && !ld_ok) || (d_aload && !a_ok);
      if (ld_ok)     m_phase = 0;
      else if (d_en) m_phase = (m_phase + 1) % DIV;
      if (ld_ok) begin
        m_t = d_lh * 3600 + d_lm * 60 + d_ls;
      end else if (adv) begin
        m_t     = (m_t + 1) % DAY;
        e.tick  = 1;
        e.wrap  = (m_t == 0);
        e.alarm = d_alm_en && (m_t == m_alm_h * 3600 + m_alm_m * 60);
      end
      if (a_ok) begin
        m_alm_h = d_ah;
        m_alm_m = d_am;
      end
      if (d_en) begin
        m_t1    = (m_t1 + 1) % DAY;
        e.tick1 = 1;
      end
    end
    e.sec    = m_t % 60;
    e.min    = (m_t / 60) % 60;
    e.hour   = m_t / 3600;
    e.hour12 = (e.hour % 12 == 0) ? 12 : e.hour % 12;
    e.pm     = (e.hour >= 12);
    e.sec1   = m_t1 % 60;
    e.min1   = (m_t1 / 60) % 60;
    q.push_back(e);
  endtask

  task automatic run(input int n, input int tag);
    repeat (n) cycle(tag);
  endtask

  task automatic do_load(input int h, input int m, input int s, input int tag);
    d_load = 1; d_lh = h; d_lm = m; d_ls = s;
    cycle(tag);
    d_load = 0;
  endtask

  // Monitor: one queued expectation per clock, compared just after the edge.
  initial begin
    bit bad;
    forever begin
      @(posedge CLK);
      #1;
      if (q.size() > 0) begin
        m_e = q.pop_front();
        bad = (int'(bus0.SEC) != m_e.sec) || (int'(bus0.MIN) != m_e.min)
           || (int'(bus0.HOUR) != m_e.hour) || (int'(bus0.HOUR12) != m_e.hour12)
           || (bus0.PM != m_e.pm) || (bus0.SEC_TICK != m_e.tick)
           || (bus0.DAY_WRAP != m_e.wrap) || (bus0.ALARM != m_e.alarm)
           || (bus0.LOAD_ERR != m_e.err) || (int'(bus1.SEC) != m_e.sec1)
           || (int'(bus1.MIN) != m_e.min1) || (bus1.SEC_TICK != m_e.tick1);
        n_checks++;
        if (bad) begin
          n_err++;
          $display("FAIL %s @%0t: got %0d:%0d:%0d h12=%0d pm=%0d tick=%0d wrap=%0d alarm=%0d err=%0d div1=%0d:%0d/%0d want %0d:%0d:%0d h12=%0d pm=%0d tick=%0d wrap=%0d alarm=%0d err=%0d div1=%0d:%0d/%0d",
                   tag_name(m_e.tag), $time,
                   bus0.HOUR, bus0.MIN, bus0.SEC, bus0.HOUR12, bus0.PM, bus0.SEC_TICK,
                   bus0.DAY_WRAP, bus0.ALARM, bus0.LOAD_ERR, bus1.MIN, bus1.SEC, bus1.SEC_TICK,
                   m_e.hour, m_e.min, m_e.sec, m_e.hour12, m_e.pm, m_e.tick,
                   m_e.wrap, m_e.alarm, m_e.err, m_e.min1, m_e.sec1, m_e.tick1);
        end
      end
    end
  end

  initial begin
    int nm;
    RST = 1'b1;
    d_rst = 1; d_en = 0; d_load = 0; d_aload = 0; d_alm_en = 0;
    d_ls = 0; d_lm = 0; d_lh = 0; d_am = 0; d_ah = 0;
    bus0.EN = 0; bus0.LOAD = 0; bus0.LD_SEC = '0; bus0.LD_MIN = '0; bus0.LD_HOUR = '0;
    bus0.ALM_LOAD = 0; bus0.ALM_MIN = '0; bus0.ALM_HOUR = '0; bus0.ALM_EN = 0;
    bus1.EN = 0; bus1.LOAD = 0; bus1.LD_SEC = '0; bus1.LD_MIN = '0; bus1.LD_HOUR = '0;
    bus1.ALM_LOAD = 0; bus1.ALM_MIN = '0; bus1.ALM_HOUR = '0; bus1.ALM_EN = 0;

    run(2, 0);
    d_rst = 0; d_en = 1;
    run(9, 1);

    do_load(23, 59, 58, 2);
    run(8, 2);

    run(1, 3);
    do_load(10, 60, 5, 3);
    run(4, 3);
    do_load(24, 0, 0, 3);
    do_load(0, 0, 60, 3);
    run(3, 3);

    d_aload = 1; d_ah = 7; d_am = 30; d_alm_en = 1;
    cycle(4);
    d_aload = 0;
    do_load(7, 29, 59, 4);
    run(5, 4);
    d_alm_en = 0;
    do_load(7, 29, 59, 4);
    run(5, 4);
    d_alm_en = 1;
    do_load(7, 30, 0, 4);
    run(6, 4);
    d_aload = 1; d_ah = 7; d_am = 60;
    cycle(4);
    d_ah = 24; d_am = 0;
    do_load(1, 2, 3, 4);
    d_aload = 0;
    do_load(7, 29, 59, 4);
    run(5, 4);

    do_load(12, 0, 0, 5);
    run(3, 5);
    do_load(13, 14, 15, 5);
    run(6, 5);

    do_load(1, 0, 0, 6);
    run(3, 6);
    do_load(25, 0, 0, 6);
    run(5, 6);

    run(2, 7);
    d_en = 0;
    run(10, 7);
    d_rst = 1;
    do_load(5, 5, 5, 7);
    d_rst = 0; d_en = 1;
    run(6, 7);

    for (int i = 0; i < 600; i++) begin
      d_rst = ($urandom_range(0, 249) == 0);
      d_en  = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 29) == 0) d_alm_en = !d_alm_en;
      d_load = ($urandom_range(0, 11) == 0);
      d_ls = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(55, 59));
      d_lm = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(57, 59));
      d_lh = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 23));
      d_aload = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 1) == 0) begin
        nm   = (m_t / 60 + 1) % 1440;
        d_ah = nm / 60;
        d_am = nm % 60;
      end else begin
        d_ah = $urandom_range(0, 31);
        d_am = $urandom_range(0, 63);
      end
      cycle(8);
    end
    d_load = 0; d_aload = 0; d_rst = 0;

    for (int i = 0; i < 10 && q.size() > 0; i++) begin
      @(posedge CLK);
      #2;
    end
    if (q.size() != 0) begin
      n_checks++;
      n_err++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/rtc_timekeeper.md
# rtc_timekeeper

Parametrised time-of-day counter with a programmable one-second prescaler, run/stop control, validated time load, 12/24-hour outputs and a minute-resolution alarm. It sits between the system clock domain and display/alarm logic. It supersedes the fixed one-second-per-cycle seconds/minutes/hours counter: it counts at a real one-second rate instead of once per clock.

## Interface
- TICK_DIV, 50_000_000: clock cycles per second; must be ≥1. Prescaler width is $clog2(TICK_DIV) (minimum 1).
- CLK  in  1  system clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- EN  in  1  run enable. Low freezes both the prescaler and the time.
- LOAD  in  1  one-cycle time-load strobe.
- LD_SEC / LD_MIN / LD_HOUR  in  6/6/5  load values (24 h).
- ALM_LOAD  in  1  alarm-register load strobe.
- ALM_MIN / ALM_HOUR  in  6/5  alarm time (24 h).
- ALM_EN  in  1  alarm enable (level).
- SEC / MIN / HOUR  out  6/6/5  current time, 24 h, registered.
- HOUR12  out  4  1–12 display hour, registered.
- PM  out  1  high for HOUR 12–23.
- SEC_TICK  out  1  one-cycle pulse; the time advanced on this edge.
- DAY_WRAP  out  1  one-cycle pulse on the 23:59:59→00:00:00 advance.
- ALARM  out  1  one-cycle alarm pulse.
- LOAD_ERR  out  1  one-cycle pulse; a load was rejected.

## Operation
- Reset: SEC=MIN=HOUR=0, HOUR12=12, PM=0, all pulses 0, prescaler=0, alarm registers 00:00.
- Prescaler counts 0..TICK_DIV-1 while EN=1 and wraps to 0. An advance occurs on the edge where prescaler==TICK_DIV-1 and EN=1.
- Advance rules:
  - SEC +1.
  - SEC 59→0 carries MIN +1.
  - MIN 59→0 carries HOUR +1.
  - HOUR 23→0 pulses DAY_WRAP.
- Load (LOAD=1):
  - Accepted only if LD_SEC≤59, LD_MIN≤59 and LD_HOUR≤23. Otherwise time is unchanged and LOAD_ERR pulses.
  - An accepted load writes the time and clears the prescaler to 0, so the next advance is exactly TICK_DIV enabled cycles later.
  - A load takes priority over a coincident advance: the advance is dropped and SEC_TICK stays 0.
  - A rejected load does not touch the prescaler, so a coincident advance still happens.
  - Loads act regardless of EN.
- ALM_LOAD:
  - Accepted only if ALM_MIN≤59 and ALM_HOUR≤23; otherwise LOAD_ERR pulses and the alarm registers keep their value.
  - If LOAD and ALM_LOAD are both high, each is validated independently, and LOAD_ERR is the OR of the two rejections.
- ALARM pulses only on an advance whose new time is ALM_HOUR:ALM_MIN:00 while ALM_EN=1. A load to that exact time does not fire the alarm.
- HOUR12/PM are derived from the next-state HOUR:
  - 0→12 AM.
  - 1–11→AM.
  - 12→12 PM.
  - 13–23→HOUR-12 PM.
  - They are updated on the same edge as HOUR.
- Deasserting EN mid-second holds the prescaler value. Reasserting EN resumes from that value; there is no restart.

## Timing
- All outputs are registered; nothing is combinational from inputs to outputs.
- SEC_TICK, DAY_WRAP and ALARM are high during the cycle after the advance edge, coincident with the updated SEC/MIN/HOUR.
- Load latency is one cycle: the new time is visible the cycle after LOAD. LOAD_ERR aligns with that same cycle.
- With TICK_DIV=1 and EN held high, the time advances every cycle.
- With TICK_DIV=N, advances are spaced exactly N enabled cycles apart.
- RST asserted mid-operation overrides LOAD, ALM_LOAD and advance on the same edge.

## Structure
- Shared package clock_pkg holds:
  - Localparams SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23.
  - Widths SEC_W=6, MIN_W=6, HOUR_W=5, HOUR12_W=4.
  - A packed struct time_t {hour, min, sec}.
  - A function to_12h(hour) returning {pm, hour12}.
- Sub-module tick_prescaler (params TICK_DIV; ports CLK, RST, EN, CLR, TICK) generates the advance strobe. CLR is driven by an accepted load.
- The top level holds the time registers, load validation, alarm compare and the 12 h conversion.

## Test plan
- Reset, then EN=1 with TICK_DIV=4 → first SEC_TICK on cycle 4 after reset release with SEC=1; SEC=2 four cycles later; HOUR12=12, PM=0 throughout.
- Load 23:59:58 (valid), then 8 enabled cycles with TICK_DIV=4 → 23:59:59, then 00:00:00 with DAY_WRAP=1 for one cycle; HOUR12=12, PM=0.
- LOAD with LD_MIN=60 → LOAD_ERR pulse, time unchanged, prescaler phase unchanged.
- ALM 07:30, ALM_EN=1, load 07:29:59 → ALARM on the next advance, coincident with 07:30:00. Repeat with ALM_EN=0 → no ALARM. Load 07:30:00 directly → no ALARM.
- LOAD coincident with the terminal prescaler cycle → loaded value shown, no SEC_TICK, next advance TICK_DIV enabled cycles later.
- EN dropped for 10 cycles mid-second, then RST asserted together with LOAD → time frozen while EN=0; after reset, all outputs equal reset values and the load is ignored.
